// File: rtl/pe_op_pkg.sv
// Shared PE op codes, sequencer state encoding and width defaults for the PE,
// its op sequencer and the array controller.
package pe_op_pkg;

  localparam int ACT_W_DEF    = 8;
  localparam int WGT_W_DEF    = 8;
  localparam int PE_OUT_W_DEF = 32;
  localparam int LEN_W_DEF    = 8;

  localparam logic [2:0] OP_WS_FLOW  = 3'b000;
  localparam logic [2:0] OP_W_LOAD   = 3'b001;
  localparam logic [2:0] OP_OS_FLOW  = 3'b100;
  localparam logic [2:0] OP_OS_DRAIN = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WS_FLOW, S_FLUSH, S_OS_CLR, S_OS_FLOW, S_OS_DRAIN, S_DONE
  } seq_state_e;

  function automatic logic is_flow(seq_state_e s);
    return (s == S_WS_FLOW) || (s == S_OS_FLOW);
  endfunction

endpackage

// File: rtl/seq_beat_counter.sv
// Job beat counter: loads len on an accepted start, counts fired flow beats
// down and holds at zero.
module seq_beat_counter
  import pe_op_pkg::*;
#(
  parameter int W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] len_i,
  output logic         zero_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt_q <= '0;
    else if (load_i)               cnt_q <= len_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/pe_op_sequencer.sv
// Sequences one PE through a weight-stationary or output-stationary job and
// collects its results. Optional stall counter: define SEQ_STALL_CNT_EN.
module pe_op_sequencer
  import pe_op_pkg::*;
#(
  parameter int ACT_WIDTH    = ACT_W_DEF,
  parameter int WGT_WIDTH    = WGT_W_DEF,
  parameter int PE_OUT_WIDTH = PE_OUT_W_DEF,
  parameter int LEN_WIDTH    = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACT_WIDTH-1:0]    in_act,
  input  logic [WGT_WIDTH-1:0]    in_wgt,
  input  logic [PE_OUT_WIDTH-1:0] in_psum,
  output logic [2:0]              pe_op,
  output logic [ACT_WIDTH-1:0]    pe_act,
  output logic [WGT_WIDTH-1:0]    pe_wgt,
  output logic [PE_OUT_WIDTH-1:0] pe_psum,
  output logic                    pe_acc_clr,
  input  logic [PE_OUT_WIDTH-1:0] pe_result,
  output logic                    out_valid,
  output logic [PE_OUT_WIDTH-1:0] out_data,
  output logic [15:0]             stall_cnt
);
  seq_state_e              state_q;
  logic                    busy_q, done_q;
  logic [1:0]              vld_pipe_q;
  logic [PE_OUT_WIDTH-1:0] out_data_q;
  logic flow, start_acc, fire, flow_fire, ws_fire, drain, cnt_zero, cnt_last;

  assign flow      = is_flow(state_q);
  assign start_acc = (state_q == S_IDLE) && start;
  assign in_ready  = (state_q == S_WLOAD) || (flow && !cnt_zero);
  assign fire      = in_valid && in_ready;
  assign flow_fire = fire && flow;
  assign ws_fire   = flow_fire && (state_q == S_WS_FLOW);
  assign drain     = (state_q == S_OS_DRAIN);

  seq_beat_counter #(.W(LEN_WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .load_i(start_acc), .dec_i(flow_fire),
    .len_i(len), .zero_o(cnt_zero), .last_o(cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          state_q <= mode ? S_OS_CLR : S_WLOAD;
          busy_q  <= 1'b1;
        end
        S_WLOAD:    if (fire) state_q <= cnt_zero ? S_FLUSH : S_WS_FLOW;
        S_WS_FLOW:  if (fire && cnt_last) state_q <= S_FLUSH;
        S_OS_CLR:   state_q <= cnt_zero ? S_OS_DRAIN : S_OS_FLOW;
        S_OS_FLOW:  if (fire && cnt_last) state_q <= S_OS_DRAIN;
        S_FLUSH, S_OS_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE:     state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // WS results land two cycles after the beat fires (PE register + capture);
  // the OS accumulator is already on pe_result during the drain cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      out_data_q <= '0;
    end else begin
      vld_pipe_q[0] <= ws_fire;
      vld_pipe_q[1] <= vld_pipe_q[0] || drain;
      if (vld_pipe_q[0] || drain) out_data_q <= pe_result;
    end
  end

  always_comb begin
    pe_op      = OP_WS_FLOW;
    pe_act     = '0;
    pe_wgt     = '0;
    pe_psum    = '0;
    pe_acc_clr = 1'b0;
    unique case (state_q)
      S_WLOAD: if (fire) begin
        pe_op  = OP_W_LOAD;
        pe_wgt = in_wgt;
      end
      S_WS_FLOW: if (fire) begin
        pe_act  = in_act;
        pe_psum = in_psum;
      end
      S_OS_CLR: begin
        pe_op      = OP_OS_FLOW;
        pe_acc_clr = 1'b1;
      end
      S_OS_FLOW: begin
        pe_op = OP_OS_FLOW;
        if (fire) begin
          pe_act = in_act;
          pe_wgt = in_wgt;
        end
      end
      S_OS_DRAIN: pe_op = OP_OS_DRAIN;
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = vld_pipe_q[1];
  assign out_data  = out_data_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        stall_q <= '0;
    else if (start_acc)                               stall_q <= '0;
    else if (flow && !in_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_op_sequencer.sv
// Bench for pe_op_sequencer paired with a behavioural PE; directed table plus
// randomized jobs checked against a job-level reference model.
`timescale 1ns/1ps
module tb_pe_op_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        start = 0, mode = 0, in_valid = 0;
  logic [7:0]  len = 0, in_act = 0, in_wgt = 0;
  logic [31:0] in_psum = 0;
  logic        busy, done, in_ready, pe_acc_clr, out_valid;
  logic [2:0]  pe_op;
  logic [7:0]  pe_act, pe_wgt;
  logic [31:0] pe_psum, pe_result, out_data;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pe_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_psum(in_psum),
    .pe_op(pe_op), .pe_act(pe_act), .pe_wgt(pe_wgt), .pe_psum(pe_psum),
    .pe_acc_clr(pe_acc_clr), .pe_result(pe_result),
    .out_valid(out_valid), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  // Behavioural PE: inputs registered at the edge, result_out valid next cycle.
  logic [7:0]  pe_wreg;
  logic [31:0] pe_acc, pe_res;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_wreg <= 0; pe_acc <= 0; pe_res <= 0;
    end else if (pe_acc_clr) begin
      pe_acc <= 0; pe_res <= 0;
    end else begin
      case (pe_op)
        3'b001: pe_wreg <= pe_wgt;
        3'b000: pe_res  <= pe_psum + 32'(pe_act) * 32'(pe_wreg);
        3'b100: begin
          pe_acc <= pe_acc + 32'(pe_act) * 32'(pe_wgt);
          pe_res <= pe_acc + 32'(pe_act) * 32'(pe_wgt);
        end
        3'b110: pe_res <= pe_acc;
        default: ;
      endcase
    end
  end
  assign pe_result = pe_res;

  // Output monitor, sampled on the falling edge.
  int          cyc = 0, done_cnt = 0, done_cyc = 0, clr_cnt = 0;
  logic [31:0] res_q[$];
  int          res_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin res_q.push_back(out_data); res_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (pe_acc_clr) clr_cnt++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Current job description and its expected outcome.
  bit          J_mode;
  int          J_len;
  logic [7:0]  J_w;
  logic [7:0]  J_a[16];
  logic [31:0] J_b[16];
  int          J_gap[16];
  logic [31:0] exp_q[$];
  int          exp_stall;

  task automatic run_job(input string nm, input bit poke);
    int rbase = res_q.size(), dbase = done_cnt, cbase = clr_cnt;
    int total = J_mode ? J_len : J_len + 1;
    int idx = 0, pend = 0, t = 0, f, nres;
    bit gapless = 1;
    for (int i = 0; i < J_len; i++) if (J_gap[i] != 0) gapless = 0;
    @(negedge clk) #1;
    start = 1; mode = J_mode; len = J_len[7:0];
    @(negedge clk) #1;
    start = 0; mode = ~J_mode; len = 8'd9;
    chk({nm, ".busy_after_start"}, busy, 1);
    while (done_cnt == dbase && t < 300) begin
      start = (poke && t == 2);
      if (idx < total) begin
        if (pend > 0) begin
          in_valid = 0; pend--;
          in_act = 8'($urandom); in_wgt = 8'($urandom); in_psum = $urandom;
        end else begin
          in_valid = 1;
          f = J_mode ? idx : idx - 1;
          if (!J_mode && idx == 0) begin
            in_wgt = J_w; in_act = 8'h5A; in_psum = 32'hDEAD_BEEF;
          end else if (J_mode) begin
            in_act = J_a[f]; in_wgt = J_b[f][7:0]; in_psum = 32'hDEAD_BEEF;
          end else begin
            in_act = J_a[f]; in_psum = J_b[f]; in_wgt = 8'hA5;
          end
        end
        if (in_valid && in_ready) begin
          idx++;
          if (idx < total) pend = J_gap[J_mode ? idx : idx - 1];
        end
      end else in_valid = 0;
      @(negedge clk) #1;
      t++;
    end
    start = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk({nm, ".done_count"}, done_cnt - dbase, 1);
    chk({nm, ".busy_after_done"}, busy, 0);
    chk({nm, ".acc_clr_pulses"}, clr_cnt - cbase, J_mode ? 1 : 0);
    nres = res_q.size() - rbase;
    chk({nm, ".result_count"}, nres, exp_q.size());
    for (int i = 0; i < nres && i < exp_q.size(); i++)
      chk($sformatf("%s.result%0d", nm, i), res_q[rbase + i], exp_q[i]);
    if (nres > 0) chk({nm, ".last_result_at_done"}, res_cyc[rbase + nres - 1], done_cyc);
    if (!J_mode && gapless)
      for (int i = 1; i < nres; i++)
        chk({nm, ".back_to_back"}, res_cyc[rbase + i] - res_cyc[rbase + i - 1], 1);
`ifdef SEQ_STALL_CNT_EN
    chk({nm, ".stall_cnt"}, stall_cnt, exp_stall);
`else
    chk({nm, ".stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  typedef struct {
    bit          mode;
    int          len;
    logic [7:0]  w;
    logic [7:0]  a[4];
    logic [31:0] b[4];
    int          gap[4];
    int          nres;
    logic [31:0] r[4];
    int          stall;
    bit          poke;
  } vec_t;
  vec_t tbl[6];

  task automatic load_vec(input int k);
    J_mode = tbl[k].mode; J_len = tbl[k].len; J_w = tbl[k].w;
    for (int i = 0; i < 16; i++) begin J_a[i] = 0; J_b[i] = 0; J_gap[i] = 0; end
    for (int i = 0; i < 4; i++) begin
      J_a[i] = tbl[k].a[i]; J_b[i] = tbl[k].b[i]; J_gap[i] = tbl[k].gap[i];
    end
    exp_q.delete();
    for (int i = 0; i < tbl[k].nres; i++) exp_q.push_back(tbl[k].r[i]);
    exp_stall = tbl[k].stall;
  endtask

  initial begin
    int rb, db;
    logic [31:0] s;
    tbl[0] = '{0, 3, 8'd3, '{8'd1, 8'd3, 8'd6, 8'd0}, '{32'd0, 32'd11, 32'd3, 32'd0},
               '{0, 0, 0, 0}, 3, '{32'd3, 32'd20, 32'd21, 32'd0}, 0, 0};
    tbl[1] = '{1, 2, 8'd0, '{8'd2, 8'd3, 8'd0, 8'd0}, '{32'd2, 32'd3, 32'd0, 32'd0},
               '{0, 0, 0, 0}, 1, '{32'd13, 32'd0, 32'd0, 32'd0}, 0, 0};
    tbl[2] = '{0, 3, 8'd3, '{8'd1, 8'd3, 8'd6, 8'd0}, '{32'd0, 32'd11, 32'd3, 32'd0},
               '{0, 2, 0, 0}, 3, '{32'd3, 32'd20, 32'd21, 32'd0}, 2, 0};
    tbl[3] = '{0, 0, 8'd7, '{8'd0, 8'd0, 8'd0, 8'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
               '{0, 0, 0, 0}, 0, '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 0};
    tbl[4] = '{1, 0, 8'd0, '{8'd0, 8'd0, 8'd0, 8'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
               '{0, 0, 0, 0}, 1, '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 0};
    tbl[5] = '{0, 3, 8'd3, '{8'd1, 8'd3, 8'd6, 8'd0}, '{32'd0, 32'd11, 32'd3, 32'd0},
               '{0, 0, 0, 0}, 3, '{32'd3, 32'd20, 32'd21, 32'd0}, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.acc_clr", pe_acc_clr, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.pe_op", pe_op, 0);
    #1 reset = 0;

    for (int k = 0; k < 6; k++) begin
      load_vec(k);
      run_job($sformatf("vec%0d", k), tbl[k].poke);
    end

    // Reset while in WS_FLOW with one beat's result still in flight.
    rb = res_q.size(); db = done_cnt;
    @(negedge clk) #1; start = 1; mode = 0; len = 8'd3;
    @(negedge clk) #1; start = 0; in_valid = 1; in_wgt = 8'd3;
    @(negedge clk) #1; in_act = 8'd1; in_psum = 32'd0;
    @(negedge clk) #1; in_valid = 0; reset = 1;
    repeat (2) @(negedge clk);
    #1 reset = 0;
    repeat (6) @(negedge clk);
    #1;
    chk("midrst.results", res_q.size() - rb, 0);
    chk("midrst.done", done_cnt - db, 0);
    chk("midrst.busy", busy, 0);
    load_vec(0);
    run_job("after_rst", 0);

    // Randomized jobs against the job-level model.
    for (int j = 0; j < 25; j++) begin
      J_mode = 1'($urandom);
      J_len  = $urandom_range(0, 6);
      J_w    = 8'($urandom);
      for (int i = 0; i < 16; i++) begin
        J_a[i]   = 8'($urandom);
        J_b[i]   = J_mode ? 32'($urandom_range(0, 255)) : $urandom;
        J_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      exp_q.delete();
      exp_stall = 0;
      s = 0;
      for (int i = 0; i < J_len; i++) begin
        if (J_mode) s = s + 32'(J_a[i]) * 32'(J_b[i][7:0]);
        else exp_q.push_back(J_b[i] + 32'(J_a[i]) * 32'(J_w));
        if (!J_mode || i > 0) exp_stall += J_gap[i];
      end
      if (J_mode) exp_q.push_back(s);
      run_job($sformatf("rnd%0d", j), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
